// File: rtl/reg_read_fwd_unit_if.sv
// Operand-resolution bus between regfile / pipeline stages and the ID-stage read/forward unit.
// Latency: purely a bundle of wires; no storage.
// Backpressure: the unit answers with stall; the master must hold ID while stall is high.
interface reg_read_fwd_unit_if #(
  parameter int READ_PORTS = 2,
  parameter int FWD_STAGES = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [READ_PORTS-1:0]            read_en;
  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0] reg_data;
  logic [FWD_STAGES-1:0]            fwd_en;
  logic [FWD_STAGES*ADDR_WIDTH-1:0] fwd_addr;
  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_data;
  logic [FWD_STAGES-1:0]            fwd_valid;
  logic                             lat_issue;
  logic [ADDR_WIDTH-1:0]            lat_issue_addr;
  logic                             lat_done;
  logic [DATA_WIDTH-1:0]            lat_done_data;
  logic                             flush;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic                             stall;
  logic                             lat_busy;

  modport master (
    output read_en, read_addr, reg_data, fwd_en, fwd_addr, fwd_data, fwd_valid,
           lat_issue, lat_issue_addr, lat_done, lat_done_data, flush,
    input  read_data, stall, lat_busy
  );

  modport slave (
    input  read_en, read_addr, reg_data, fwd_en, fwd_addr, fwd_data, fwd_valid,
           lat_issue, lat_issue_addr, lat_done, lat_done_data, flush,
    output read_data, stall, lat_busy
  );
endinterface

// File: rtl/reg_read_fwd_unit.sv
// Resolves ID-stage register reads against in-order forwarding stages and one pending long-latency op.
// Latency: operands and stall are combinational (zero cycles); scoreboard updates on posedge clk.
// Backpressure: stall is raised on any unresolved RAW hazard; state does not depend on stall.
// Optional REG_FWD_PERF_EN adds perf_stall_cnt / perf_fwd_cnt event counters.
module reg_read_fwd_unit #(
  parameter int READ_PORTS = 2,
  parameter int FWD_STAGES = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_read_fwd_unit_if.slave   bus
`ifdef REG_FWD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_fwd_cnt
`endif
);

  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;

  logic [READ_PORTS*DATA_WIDTH-1:0] read_data_c;
  logic [READ_PORTS-1:0]            hazard;
  logic [READ_PORTS-1:0]            fwd_matched;
`ifdef REG_FWD_PERF_EN
  logic [READ_PORTS-1:0]            fwd_hit;
  logic [31:0]                      fwd_inc;
`endif

  // Scoreboard: flush cancels, a new issue beats a same-cycle done (that done belongs to the older op).
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else if (bus.flush) begin
      pend_valid <= 1'b0;
    end else if (bus.lat_issue && (bus.lat_issue_addr != '0)) begin
      pend_valid <= 1'b1;
      pend_addr  <= bus.lat_issue_addr;
    end else if (bus.lat_done) begin
      pend_valid <= 1'b0;
    end
  end

  // Per-port resolution: youngest matching stage wins, then the pending long op, then the regfile.
  always_comb begin
    read_data_c = '0;
    hazard      = '0;
    fwd_matched = '0;
`ifdef REG_FWD_PERF_EN
    fwd_hit     = '0;
`endif
    for (int p = 0; p < READ_PORTS; p++) begin
      if (bus.read_en[p] && (bus.read_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        for (int s = 0; s < FWD_STAGES; s++) begin
          if (!fwd_matched[p] && bus.fwd_en[s] &&
              (bus.fwd_addr[s*ADDR_WIDTH +: ADDR_WIDTH] == bus.read_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            fwd_matched[p] = 1'b1;
            if (bus.fwd_valid[s]) begin
              read_data_c[p*DATA_WIDTH +: DATA_WIDTH] = bus.fwd_data[s*DATA_WIDTH +: DATA_WIDTH];
`ifdef REG_FWD_PERF_EN
              fwd_hit[p] = 1'b1;
`endif
            end else begin
              hazard[p] = 1'b1;
            end
          end
        end
        if (!fwd_matched[p]) begin
          if (pend_valid && (pend_addr == bus.read_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            if (bus.lat_done) begin
              read_data_c[p*DATA_WIDTH +: DATA_WIDTH] = bus.lat_done_data;
`ifdef REG_FWD_PERF_EN
              fwd_hit[p] = 1'b1;
`endif
            end else begin
              hazard[p] = 1'b1;
            end
          end else begin
            read_data_c[p*DATA_WIDTH +: DATA_WIDTH] = bus.reg_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  assign bus.read_data = read_data_c;
  assign bus.stall     = |hazard;
  assign bus.lat_busy  = pend_valid;

`ifdef REG_FWD_PERF_EN
  // Number of ports served with valid bypassed data this cycle.
  always_comb begin
    fwd_inc = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      fwd_inc = fwd_inc + {31'd0, fwd_hit[p]};
    end
  end

  // Free-running event counters; only reset clears them, they wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, bus.stall};
      perf_fwd_cnt   <= perf_fwd_cnt + fwd_inc;
    end
  end
`endif

endmodule

// File: tb/tb_reg_read_fwd_unit.sv
module tb_reg_read_fwd_unit;
  localparam int RP = 2;
  localparam int FS = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [DW-1:0] REG0 = 32'h0000_AA00;
  localparam logic [DW-1:0] REG1 = 32'h0000_BB11;

  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_read_fwd_unit_if #(.READ_PORTS(RP), .FWD_STAGES(FS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

`ifdef REG_FWD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  reg_read_fwd_unit #(.READ_PORTS(RP), .FWD_STAGES(FS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef REG_FWD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  function automatic logic [DW-1:0] rd(input int p);
    return bus.read_data[p*DW +: DW];
  endfunction

  task automatic idle();
    bus.read_en        = '0;
    bus.read_addr      = '0;
    bus.reg_data       = {REG1, REG0};
    bus.fwd_en         = '0;
    bus.fwd_addr       = '0;
    bus.fwd_data       = '0;
    bus.fwd_valid      = '0;
    bus.lat_issue      = 1'b0;
    bus.lat_issue_addr = '0;
    bus.lat_done       = 1'b0;
    bus.lat_done_data  = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic set_read(input int p, input logic en, input logic [AW-1:0] a);
    bus.read_en[p]           = en;
    bus.read_addr[p*AW +: AW] = a;
  endtask

  task automatic set_fwd(input int s, input logic en, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic v);
    bus.fwd_en[s]             = en;
    bus.fwd_addr[s*AW +: AW]  = a;
    bus.fwd_data[s*DW +: DW]  = d;
    bus.fwd_valid[s]          = v;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    step();
    #1;
    vectors++;
    if (bus.lat_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", bus.lat_busy); end
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
    vectors++;
    if (bus.read_data !== '0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", bus.read_data); end
    set_read(0, 1'b1, 5'd3);
    #1;
    vectors++;
    if (rd(0) !== REG0) begin miscompares++; $display("FAIL reset_regread got %h want %h", rd(0), REG0); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fwd_priority();
    idle();
    set_read(0, 1'b1, 5'd5);
    set_fwd(0, 1'b1, 5'd5, 32'hAAAA_0001, 1'b1);
    set_fwd(1, 1'b1, 5'd5, 32'hBBBB_0002, 1'b1);
    set_fwd(2, 1'b1, 5'd5, 32'hCCCC_0003, 1'b1);
    #1;
    vectors++;
    if (rd(0) !== 32'hAAAA_0001) begin miscompares++; $display("FAIL fwd_youngest got %h want AAAA0001", rd(0)); end
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall got %0b want 0", bus.stall); end
    bus.fwd_en[0] = 1'b0;
    #1;
    vectors++;
    if (rd(0) !== 32'hBBBB_0002) begin miscompares++; $display("FAIL fwd_mid got %h want BBBB0002", rd(0)); end
    bus.fwd_en[1] = 1'b0;
    #1;
    vectors++;
    if (rd(0) !== 32'hCCCC_0003) begin miscompares++; $display("FAIL fwd_oldest got %h want CCCC0003", rd(0)); end
    step();
  endtask

  task automatic test_load_use();
    idle();
    set_read(1, 1'b1, 5'd7);
    set_fwd(0, 1'b1, 5'd7, 32'hDEAD_0000, 1'b0);
    set_fwd(1, 1'b1, 5'd7, 32'h5555_5555, 1'b1);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL loaduse_stall got %0b want 1", bus.stall); end
    step();
    set_fwd(0, 1'b1, 5'd7, 32'h0000_1234, 1'b1);
    #1;
    vectors++;
    if (rd(1) !== 32'h0000_1234) begin miscompares++; $display("FAIL loaduse_data got %h want 00001234", rd(1)); end
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL loaduse_release got %0b want 0", bus.stall); end
    step();
  endtask

  task automatic test_lat_op();
    idle();
    bus.lat_issue      = 1'b1;
    bus.lat_issue_addr = 5'd9;
    step();
    bus.lat_issue = 1'b0;
    vectors++;
    if (bus.lat_busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_set got %0b want 1", bus.lat_busy); end
    set_read(0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL lat_stall cyc%0d got %0b want 1", i, bus.stall); end
      step();
    end
    bus.lat_done      = 1'b1;
    bus.lat_done_data = 32'h0000_DEAD;
    #1;
    vectors++;
    if (rd(0) !== 32'h0000_DEAD) begin miscompares++; $display("FAIL lat_bypass got %h want 0000DEAD", rd(0)); end
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL lat_done_stall got %0b want 0", bus.stall); end
    step();
    bus.lat_done = 1'b0;
    #1;
    vectors++;
    if (bus.lat_busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy_clr got %0b want 0", bus.lat_busy); end
    vectors++;
    if (rd(0) !== REG0) begin miscompares++; $display("FAIL lat_after got %h want %h", rd(0), REG0); end
    step();
  endtask

  task automatic test_flush();
    idle();
    bus.lat_issue      = 1'b1;
    bus.lat_issue_addr = 5'd4;
    step();
    bus.lat_issue = 1'b0;
    bus.flush     = 1'b1;
    set_read(0, 1'b1, 5'd4);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL flush_comb_stall got %0b want 1", bus.stall); end
    step();
    bus.flush = 1'b0;
    #1;
    vectors++;
    if (bus.lat_busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %0b want 0", bus.lat_busy); end
    vectors++;
    if (rd(0) !== REG0) begin miscompares++; $display("FAIL flush_read got %h want %h", rd(0), REG0); end
    step();
  endtask

  task automatic test_issue_done();
    idle();
    bus.lat_issue      = 1'b1;
    bus.lat_issue_addr = 5'd10;
    step();
    // New issue to r6 in the same cycle the r10 op completes.
    bus.lat_issue_addr = 5'd6;
    bus.lat_done       = 1'b1;
    bus.lat_done_data  = 32'h0000_BEEF;
    set_read(0, 1'b1, 5'd10);
    #1;
    vectors++;
    if (rd(0) !== 32'h0000_BEEF) begin miscompares++; $display("FAIL issdone_bypass got %h want 0000BEEF", rd(0)); end
    step();
    bus.lat_issue = 1'b0;
    bus.lat_done  = 1'b0;
    #1;
    vectors++;
    if (bus.lat_busy !== 1'b1) begin miscompares++; $display("FAIL issdone_busy got %0b want 1", bus.lat_busy); end
    vectors++;
    if (bus.stall !== 1'b0 || rd(0) !== REG0) begin
      miscompares++; $display("FAIL issdone_old_addr stall=%0b data=%h want 0/%h", bus.stall, rd(0), REG0);
    end
    set_read(0, 1'b1, 5'd6);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL issdone_pend6 got %0b want 1", bus.stall); end
    // A younger in-order write to r6 shadows the pending value.
    set_fwd(2, 1'b1, 5'd6, 32'h0000_0777, 1'b1);
    #1;
    vectors++;
    if (bus.stall !== 1'b0 || rd(0) !== 32'h0000_0777) begin
      miscompares++; $display("FAIL shadow stall=%0b data=%h want 0/00000777", bus.stall, rd(0));
    end
    bus.fwd_en   = '0;
    bus.lat_done = 1'b1;
    step();
    bus.lat_done = 1'b0;
    #1;
    vectors++;
    if (bus.lat_busy !== 1'b0) begin miscompares++; $display("FAIL issdone_drain got %0b want 0", bus.lat_busy); end
    step();
  endtask

  task automatic test_zero_and_disable();
    idle();
    bus.lat_issue      = 1'b1;
    bus.lat_issue_addr = 5'd0;
    step();
    bus.lat_issue = 1'b0;
    vectors++;
    if (bus.lat_busy !== 1'b0) begin miscompares++; $display("FAIL zero_issue_busy got %0b want 0", bus.lat_busy); end
    set_read(0, 1'b1, 5'd0);
    set_read(1, 1'b1, 5'd0);
    set_fwd(0, 1'b1, 5'd0, 32'h1111_1111, 1'b0);
    set_fwd(1, 1'b1, 5'd0, 32'h2222_2222, 1'b1);
    #1;
    vectors++;
    if (bus.read_data !== '0 || bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL zero_addr data=%h stall=%0b want 0/0", bus.read_data, bus.stall);
    end
    set_read(0, 1'b0, 5'd5);
    set_read(1, 1'b0, 5'd5);
    set_fwd(0, 1'b1, 5'd5, 32'h3333_3333, 1'b0);
    #1;
    vectors++;
    if (bus.read_data !== '0 || bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL read_dis data=%h stall=%0b want 0/0", bus.read_data, bus.stall);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    bus.lat_issue      = 1'b1;
    bus.lat_issue_addr = 5'd12;
    step();
    bus.lat_issue = 1'b0;
    set_read(1, 1'b1, 5'd12);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got %0b want 1", bus.stall); end
    rst = 1'b0;
    step();
    vectors++;
    if (bus.lat_busy !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL rstmid busy=%0b stall=%0b want 0/0", bus.lat_busy, bus.stall);
    end
    vectors++;
    if (rd(1) !== REG1) begin miscompares++; $display("FAIL rstmid_read got %h want %h", rd(1), REG1); end
    rst = 1'b1;
    step();
  endtask

`ifdef REG_FWD_PERF_EN
  task automatic test_perf();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    set_read(0, 1'b1, 5'd7);
    set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    idle();
    set_read(0, 1'b1, 5'd5);
    set_read(1, 1'b1, 5'd5);
    set_fwd(0, 1'b1, 5'd5, 32'h0000_00AB, 1'b1);
    step();
    idle();
    step();
    vectors++;
    if (perf_stall_cnt !== 32'd3) begin miscompares++; $display("FAIL perf_stall got %0d want 3", perf_stall_cnt); end
    vectors++;
    if (perf_fwd_cnt !== 32'd2) begin miscompares++; $display("FAIL perf_fwd got %0d want 2", perf_fwd_cnt); end
    rst = 1'b0;
    step();
    vectors++;
    if (perf_stall_cnt !== 32'd0 || perf_fwd_cnt !== 32'd0) begin
      miscompares++; $display("FAIL perf_rst stall=%0d fwd=%0d want 0/0", perf_stall_cnt, perf_fwd_cnt);
    end
    rst = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_lat_op();
    test_flush();
    test_issue_done();
    test_zero_and_disable();
    test_reset_mid_stall();
`ifdef REG_FWD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
